// File: rtl/approx_multiplier_4x4_if.sv
// Operand/product bus for approx_multiplier_4x4.
// err_flag exists only when APPROX_ERR_FLAG_EN is defined.
interface approx_multiplier_4x4_if;
   localparam int unsigned OP_W   = 4;
   localparam int unsigned PROD_W = 8;

   logic              in_valid;
   logic [OP_W-1:0]   A;
   logic [OP_W-1:0]   X;
   logic              out_valid;
   logic [PROD_W-1:0] product;
`ifdef APPROX_ERR_FLAG_EN
   logic              err_flag;

   modport master (output in_valid, A, X, input out_valid, product, err_flag);
   modport slave  (input in_valid, A, X, output out_valid, product, err_flag);
`else
   modport master (output in_valid, A, X, input out_valid, product);
   modport slave  (input in_valid, A, X, output out_valid, product);
`endif
endinterface

// File: rtl/approx_multiplier_4x4.sv
// Registered 4x4 unsigned approximate recursive multiplier built from four 2x2 blocks.
// Optional APPROX_ERR_FLAG_EN adds a registered err_flag (approx != exact).
module approx_multiplier_4x4 #(
   parameter logic [3:0] APPROX_MASK = 4'b1111
) (
   input  logic                         clk,
   input  logic                         rst,
   approx_multiplier_4x4_if.slave       bus
);
   localparam int unsigned OP_W   = 4;
   localparam int unsigned HALF_W = 2;
   localparam int unsigned SUB_W  = 4;
   localparam int unsigned PROD_W = 8;

   // 2x2 sub-multiplier; the approximate form maps 3*3 to 7 so it fits in 3 bits
   function automatic logic [SUB_W-1:0] mul2x2(input logic [HALF_W-1:0] a,
                                               input logic [HALF_W-1:0] b,
                                               input logic              approx);
      logic [SUB_W-1:0] r;
      r = SUB_W'(a) * SUB_W'(b);
      if (approx && (a == 2'd3) && (b == 2'd3)) begin
         r = 4'd7;
      end
      return r;
   endfunction

   logic [HALF_W-1:0] al_c, ah_c, xl_c, xh_c;
   logic [SUB_W-1:0]  ll_c, hl_c, lh_c, hh_c;
   logic [PROD_W-1:0] p_c;

   logic [PROD_W-1:0] product_d, product_q;
   logic              out_valid_d, out_valid_q;

   // Operand split and recombination of the sub-products with exact adders
   always_comb begin
      al_c = bus.A[1:0];
      ah_c = bus.A[3:2];
      xl_c = bus.X[1:0];
      xh_c = bus.X[3:2];
      ll_c = mul2x2(al_c, xl_c, APPROX_MASK[0]);
      hl_c = mul2x2(ah_c, xl_c, APPROX_MASK[1]);
      lh_c = mul2x2(al_c, xh_c, APPROX_MASK[2]);
      hh_c = mul2x2(ah_c, xh_c, APPROX_MASK[3]);
      p_c  = PROD_W'(ll_c)
           + ((PROD_W'(hl_c) + PROD_W'(lh_c)) << 2)
           + (PROD_W'(hh_c) << 4);
   end

   // Product holds across idle cycles; out_valid follows in_valid
   always_comb begin
      product_d   = product_q;
      out_valid_d = bus.in_valid;
      if (bus.in_valid) begin
         product_d = p_c;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         product_q   <= '0;
         out_valid_q <= 1'b0;
      end else begin
         product_q   <= product_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.product   = product_q;
   assign bus.out_valid = out_valid_q;

`ifdef APPROX_ERR_FLAG_EN
   logic [PROD_W-1:0] exact_c;
   logic              err_flag_d, err_flag_q;

   // Reference exact product for the error indicator
   always_comb begin
      exact_c    = PROD_W'(bus.A) * PROD_W'(bus.X);
      err_flag_d = 1'b0;
      if (bus.in_valid) begin
         err_flag_d = (p_c != exact_c);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_flag_q <= 1'b0;
      end else begin
         err_flag_q <= err_flag_d;
      end
   end

   assign bus.err_flag = err_flag_q;
`endif

endmodule

// File: tb/tb_approx_multiplier_4x4.sv
// Scoreboard bench for approx_multiplier_4x4: default mask and all-exact mask side by side.
module tb_approx_multiplier_4x4;
   logic clk;
   logic rst;

   approx_multiplier_4x4_if if0 ();
   approx_multiplier_4x4_if if1 ();

   approx_multiplier_4x4 u_dut_apx (.clk(clk), .rst(rst), .bus(if0));
   approx_multiplier_4x4 #(.APPROX_MASK(4'b0000)) u_dut_exact (.clk(clk), .rst(rst), .bus(if1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] a;
      logic [3:0] x;
      logic [7:0] p0;
      logic [7:0] p1;
      bit         exh;
   } sb_t;

   sb_t sb_q[$];
   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   int unsigned exh_exact0 = 0, exh_mism0 = 0, exh_below0 = 0, exh_exact1 = 0;

   task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Exact product minus 2<<shift for every masked 3*3 sub-product
   function automatic int unsigned model(input logic [3:0] a, input logic [3:0] x,
                                         input logic [3:0] mask);
      int unsigned r;
      logic [1:0] ad [2];
      logic [1:0] xd [2];
      r = int'(a) * int'(x);
      ad[0] = a[1:0]; ad[1] = a[3:2];
      xd[0] = x[1:0]; xd[1] = x[3:2];
      for (int i = 0; i < 2; i++) begin
         for (int j = 0; j < 2; j++) begin
            if (mask[i + 2*j] && ad[i] == 2'd3 && xd[j] == 2'd3) begin
               r = r - (2 << (2*(i + j)));
            end
         end
      end
      return r;
   endfunction

   task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] x,
                        input logic r, input int exp_ov = -1, input bit exh = 1'b0);
      sb_t it;
      @(negedge clk);
      rst = r;
      if0.in_valid = v; if0.A = a; if0.X = x;
      if1.in_valid = v; if1.A = a; if1.X = x;
      if (v && !r) begin
         it.a   = a;
         it.x   = x;
         it.p0  = (exp_ov >= 0) ? 8'(exp_ov) : 8'(model(a, x, 4'b1111));
         it.p1  = 8'(model(a, x, 4'b0000));
         it.exh = exh;
         sb_q.push_back(it);
      end
   endtask

   // Output monitor: every valid product is matched against the scoreboard head
   always @(negedge clk) begin
      sb_t it;
      if (if0.out_valid || if1.out_valid) begin
         if (sb_q.size() == 0) begin
            check_eq("unexpected_valid", 1, 0);
         end else begin
            it = sb_q.pop_front();
            check_eq($sformatf("prod_apx %0d*%0d", it.a, it.x), if0.product, it.p0);
            check_eq($sformatf("prod_exact %0d*%0d", it.a, it.x), if1.product, it.p1);
            check_eq("ov_apx", if0.out_valid, 1);
            check_eq("ov_exact", if1.out_valid, 1);
`ifdef APPROX_ERR_FLAG_EN
            check_eq($sformatf("err_flag %0d*%0d", it.a, it.x), if0.err_flag,
                     (int'(it.p0) != int'(it.a) * int'(it.x)) ? 1 : 0);
            check_eq("err_flag_exact", if1.err_flag, 0);
`endif
            if (it.exh) begin
               if (int'(if0.product) == int'(it.a) * int'(it.x)) exh_exact0++;
               else exh_mism0++;
               if (int'(if0.product) < int'(it.a) * int'(it.x)) exh_below0++;
               if (int'(if1.product) == int'(it.a) * int'(it.x)) exh_exact1++;
            end
         end
      end
   end

   task automatic check_idle(input string tag, input int unsigned p0, input int unsigned p1);
      check_eq({tag, "_ov_apx"}, if0.out_valid, 0);
      check_eq({tag, "_ov_exact"}, if1.out_valid, 0);
      check_eq({tag, "_prod_apx"}, if0.product, p0);
      check_eq({tag, "_prod_exact"}, if1.product, p1);
`ifdef APPROX_ERR_FLAG_EN
      check_eq({tag, "_err_flag"}, if0.err_flag, 0);
`endif
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 5 && sb_q.size() != 0; i++) @(negedge clk);
      check_eq({tag, "_sb_drain"}, sb_q.size(), 0);
   endtask

   initial begin
      rst = 1'b1;
      if0.in_valid = 1'b0; if0.A = '0; if0.X = '0;
      if1.in_valid = 1'b0; if1.A = '0; if1.X = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_idle("reset", 0, 0);
      drive(1'b0, 4'd0, 4'd0, 1'b0);
      @(negedge clk);
      check_idle("post_reset", 0, 0);

      // Directed single operations with known products
      drive(1'b1, 4'd3,  4'd3,  1'b0, 7);
      drive(1'b1, 4'd5,  4'd6,  1'b0, 30);
      drive(1'b1, 4'd12, 4'd13, 1'b0, 124);
      drive(1'b1, 4'd15, 4'd15, 1'b0, 175);
      drive(1'b0, 4'd0,  4'd0,  1'b0);
      drain("singles");

      // Valid gap: product holds, out_valid drops
      drive(1'b1, 4'd2, 4'd7, 1'b0, 14);
      drive(1'b0, 4'd9, 4'd9, 1'b0);
      @(negedge clk);
      check_idle("hold", 14, 14);

      // Reset overrides a valid operand on the same edge
      drive(1'b1, 4'd9, 4'd11, 1'b0);
      drive(1'b1, 4'd4, 4'd4,  1'b1);
      @(negedge clk);
      check_idle("mid_reset", 0, 0);
      drive(1'b0, 4'd0, 4'd0, 1'b0);

      // Exhaustive back-to-back sweep
      exh_exact0 = 0; exh_mism0 = 0; exh_below0 = 0; exh_exact1 = 0;
      for (int a = 0; a < 16; a++) begin
         for (int x = 0; x < 16; x++) begin
            drive(1'b1, 4'(a), 4'(x), 1'b0, -1, 1'b1);
         end
      end
      drive(1'b0, 4'd0, 4'd0, 1'b0);
      drain("exhaustive");
      check_eq("exh_exact_apx", exh_exact0, 207);
      check_eq("exh_mismatch_apx", exh_mism0, 49);
      check_eq("exh_below_apx", exh_below0, 49);
      check_eq("exh_exact_mask0", exh_exact1, 256);
      @(negedge clk);
      check_idle("final", 8'(model(4'd15, 4'd15, 4'b1111)), 225);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t limit %0d", $time, 200000);
      $fatal(1, "watchdog");
   end
endmodule
